// File: rtl/fifo_rr_arbiter_if.sv
// fifo_rr_arbiter_if: arbiter bus (state, source FIFO flags/data/pops, destination push/data/grant, idle); master = arbiter, slave = FIFO side
interface fifo_rr_arbiter_if #(
  parameter int DATA_W = 10,
  parameter int N_CH   = 4,
  parameter int PTR_W  = 2
);
  logic [3:0]             state;
  logic [N_CH-1:0]        fifo_empty;
  logic [N_CH*DATA_W-1:0] fifo_data;
  logic [N_CH-1:0]        fifo_pop;
  logic                   dest_almost_full;
  logic                   push_out;
  logic [DATA_W-1:0]      data_out;
  logic [PTR_W-1:0]       grant_ch;
  logic                   idle;
  modport master (
    input  state, fifo_empty, fifo_data, dest_almost_full,
    output fifo_pop, push_out, data_out, grant_ch, idle
  );
  modport slave (
    output state, fifo_empty, fifo_data, dest_almost_full,
    input  fifo_pop, push_out, data_out, grant_ch, idle
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin pop of N_CH source FIFOs forwarded as 2-cycle-latency pushes; ports clk, reset (async high), bus (master modport)
module fifo_rr_arbiter #(
  parameter int DATA_W = 10,
  parameter int N_CH   = 4,
  parameter int PTR_W  = 2
) (
  input  logic               clk,
  input  logic               reset,
  fifo_rr_arbiter_if.master  bus
);
  logic [PTR_W-1:0] ptr, sel, idx, pop_ch, cap_ch;
  logic             found, go, cap_valid;
  always_comb begin
    sel   = ptr;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      idx = ptr + PTR_W'(k);
      if (!found && !bus.fifo_empty[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end
  assign go       = (bus.state == 4'b1000) && !bus.dest_almost_full && found;
  assign bus.idle = ~|bus.fifo_pop & ~cap_valid & ~bus.push_out & (&bus.fifo_empty);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.fifo_pop <= '0;
      bus.push_out <= 1'b0;
      bus.data_out <= '0;
      bus.grant_ch <= '0;
      ptr          <= '0;
      pop_ch       <= '0;
      cap_ch       <= '0;
      cap_valid    <= 1'b0;
    end else begin
      bus.fifo_pop <= go ? N_CH'(1) << sel : '0;
      ptr          <= go ? sel + 1'b1 : ptr;
      pop_ch       <= sel;
      cap_valid    <= |bus.fifo_pop;
      cap_ch       <= pop_ch;
      bus.push_out <= cap_valid;
      bus.data_out <= cap_valid ? bus.fifo_data[cap_ch*DATA_W +: DATA_W] : bus.data_out;
      bus.grant_ch <= cap_valid ? cap_ch : bus.grant_ch;
    end
  end
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: table-driven check of fifo_rr_arbiter against pop-aware source FIFO models
module tb_fifo_rr_arbiter;
  localparam int DW = 10;
  localparam int N  = 4;
  localparam int PW = 2;
  localparam logic [3:0] ACT = 4'b1000;
  localparam logic [3:0] IDL = 4'b0100;
  typedef struct {
    logic [3:0]    st;
    logic          af;
    logic          ld;
    int            ld_ch;
    logic [DW-1:0] ld_val;
    logic [N-1:0]  pop;
    logic          push;
    logic [DW-1:0] data;
    logic [PW-1:0] gnt;
    logic          idle;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  fifo_rr_arbiter_if #(.DATA_W(DW), .N_CH(N), .PTR_W(PW)) bus();
  fifo_rr_arbiter #(.DATA_W(DW), .N_CH(N), .PTR_W(PW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  logic [DW-1:0] mem [N][64];
  int            wr [N] = '{default: 0};
  int            rd [N] = '{default: 0};
  logic [DW-1:0] src_q [N] = '{default: '0};
  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (bus.fifo_pop[i]) begin
        src_q[i] <= mem[i][rd[i] % 64];
        rd[i]    <= rd[i] + 1;
      end
  // empty already reflects a pop being presented this cycle, so the last word shows empty while it is popped
  always_comb begin
    bus.fifo_empty = '1;
    bus.fifo_data  = '0;
    for (int i = 0; i < N; i++) begin
      bus.fifo_empty[i]         = (wr[i] - rd[i]) <= int'(bus.fifo_pop[i]);
      bus.fifo_data[i*DW +: DW] = src_q[i];
    end
  end
  function automatic vec_t mk(logic [3:0] st, logic af, logic [N-1:0] pop, logic push,
                              logic [DW-1:0] data, int gnt, logic idle);
    vec_t v;
    v.st = st; v.af = af; v.ld = 1'b0; v.ld_ch = 0; v.ld_val = '0;
    v.pop = pop; v.push = push; v.data = data; v.gnt = PW'(gnt); v.idle = idle;
    return v;
  endfunction
  task automatic chk(string nm, int r, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %0h want %0h", nm, r, got, exp);
    end
  endtask
  task automatic load(int ch, logic [DW-1:0] v);
    mem[ch][wr[ch] % 64] = v;
    wr[ch]++;
  endtask
  task automatic guard();
    logic [N-1:0] ufl;
    for (int i = 0; i < N; i++) ufl[i] = bus.fifo_pop[i] && (wr[i] == rd[i]);
    chk("pop_to_empty", -1, 32'(ufl), 0);
    chk("pop_onehot", -1, 32'($onehot0(bus.fifo_pop)), 1);
  endtask
  task automatic tick();
    guard();
    @(posedge clk);
    #1;
  endtask
  task automatic run(int a, int b);
    for (int r = a; r <= b; r++) begin
      bus.state            = tbl[r].st;
      bus.dest_almost_full = tbl[r].af;
      if (tbl[r].ld) load(tbl[r].ld_ch, tbl[r].ld_val);
      tick();
      chk("fifo_pop", r, 32'(bus.fifo_pop), 32'(tbl[r].pop));
      chk("push_out", r, 32'(bus.push_out), 32'(tbl[r].push));
      chk("data_out", r, 32'(bus.data_out), 32'(tbl[r].data));
      chk("grant_ch", r, 32'(bus.grant_ch), 32'(tbl[r].gnt));
      chk("idle", r, 32'(bus.idle), 32'(tbl[r].idle));
    end
  endtask
  task automatic chk_reset_outs(int r);
    chk("rst_pop", r, 32'(bus.fifo_pop), 0);
    chk("rst_push", r, 32'(bus.push_out), 0);
    chk("rst_data", r, 32'(bus.data_out), 0);
    chk("rst_grant", r, 32'(bus.grant_ch), 0);
    chk("rst_idle", r, 32'(bus.idle), 1);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    // single channel ch2 holding 3 words
    tbl.push_back(mk(ACT, 0, 4'b0100, 0, 10'h000, 0, 0));
    tbl.push_back(mk(ACT, 0, 4'b0100, 0, 10'h000, 0, 0));
    tbl.push_back(mk(ACT, 0, 4'b0100, 1, 10'h001, 2, 0));
    tbl.push_back(mk(ACT, 0, 4'b0000, 1, 10'h002, 2, 0));
    tbl.push_back(mk(ACT, 0, 4'b0000, 1, 10'h003, 2, 0));
    tbl.push_back(mk(ACT, 0, 4'b0000, 0, 10'h003, 2, 1));
    // all channels busy, almost_full throttle, then leave ACTIVE with 2 in flight
    tbl.push_back(mk(ACT, 0, 4'b0001, 0, 10'h000, 0, 0));
    tbl.push_back(mk(ACT, 0, 4'b0010, 0, 10'h000, 0, 0));
    tbl.push_back(mk(ACT, 0, 4'b0100, 1, 10'h001, 0, 0));
    tbl.push_back(mk(ACT, 0, 4'b1000, 1, 10'h011, 1, 0));
    tbl.push_back(mk(ACT, 0, 4'b0001, 1, 10'h021, 2, 0));
    tbl.push_back(mk(ACT, 0, 4'b0010, 1, 10'h031, 3, 0));
    tbl.push_back(mk(ACT, 1, 4'b0000, 1, 10'h002, 0, 0));
    tbl.push_back(mk(ACT, 1, 4'b0000, 1, 10'h012, 1, 0));
    tbl.push_back(mk(ACT, 1, 4'b0000, 0, 10'h012, 1, 0));
    tbl.push_back(mk(ACT, 0, 4'b0100, 0, 10'h012, 1, 0));
    tbl.push_back(mk(ACT, 0, 4'b1000, 0, 10'h012, 1, 0));
    tbl.push_back(mk(IDL, 0, 4'b0000, 1, 10'h022, 2, 0));
    tbl.push_back(mk(IDL, 0, 4'b0000, 1, 10'h032, 3, 0));
    tbl.push_back(mk(IDL, 0, 4'b0000, 0, 10'h032, 3, 1));
    // ch1 goes empty on its turn, pointer skips back to ch0
    tbl.push_back(mk(ACT, 0, 4'b0001, 0, 10'h032, 3, 0));
    tbl.push_back(mk(ACT, 0, 4'b0010, 0, 10'h032, 3, 0));
    tbl.push_back(mk(ACT, 0, 4'b0001, 1, 10'h041, 0, 0));
    tbl.push_back(mk(ACT, 0, 4'b0001, 1, 10'h051, 1, 0));
    tbl.push_back(mk(ACT, 0, 4'b0000, 1, 10'h042, 0, 0));
    tbl.push_back(mk(ACT, 0, 4'b0000, 1, 10'h043, 0, 0));
    tbl.push_back(mk(ACT, 0, 4'b0000, 0, 10'h043, 0, 1));
    // non-one-hot states, then almost_full, then ACTIVE
    tbl.push_back(mk(4'b1100, 0, 4'b0000, 0, 10'h043, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 0, 10'h043, 0, 0));
    tbl.push_back(mk(ACT, 1, 4'b0000, 0, 10'h043, 0, 0));
    tbl.push_back(mk(ACT, 0, 4'b1000, 0, 10'h043, 0, 0));
    tbl.push_back(mk(ACT, 0, 4'b0000, 0, 10'h043, 0, 0));
    tbl.push_back(mk(ACT, 0, 4'b0000, 1, 10'h071, 3, 0));
    tbl.push_back(mk(ACT, 0, 4'b0000, 0, 10'h071, 3, 1));
    // almost_full rises the same cycle ch1 becomes non-empty
    tbl.push_back(mk(ACT, 1, 4'b0000, 0, 10'h071, 3, 0));
    tbl[$].ld = 1'b1; tbl[$].ld_ch = 1; tbl[$].ld_val = 10'h081;
    tbl.push_back(mk(ACT, 0, 4'b0010, 0, 10'h071, 3, 0));
    tbl.push_back(mk(ACT, 0, 4'b0000, 0, 10'h071, 3, 0));
    tbl.push_back(mk(ACT, 0, 4'b0000, 1, 10'h081, 1, 0));
    tbl.push_back(mk(ACT, 0, 4'b0000, 0, 10'h081, 1, 1));
    reset = 1'b1;
    bus.state = 4'b0001;
    bus.dest_almost_full = 1'b0;
    repeat (2) tick();
    chk_reset_outs(-2);
    reset = 1'b0;
    bus.state = IDL;
    tick();
    chk("post_rst_idle", -3, 32'(bus.idle), 1);
    load(2, 10'h001); load(2, 10'h002); load(2, 10'h003);
    run(0, 5);
    // reset with a word in flight: ptr is 3, so ch1 is found after wrapping
    load(1, 10'h011);
    tick();
    chk("mid_pop", -4, 32'(bus.fifo_pop), 32'(4'b0010));
    tick();
    chk("mid_pop2", -4, 32'(bus.fifo_pop), 0);
    chk("mid_idle", -4, 32'(bus.idle), 0);
    reset = 1'b1;
    #1;
    chk_reset_outs(-5);
    repeat (2) tick();
    reset = 1'b0;
    bus.state = IDL;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("no_stale_push", -6, 32'(bus.push_out), 0);
      chk("no_stale_idle", -6, 32'(bus.idle), 1);
    end
    for (int c = 0; c < N; c++) begin
      load(c, DW'(c * 16 + 1));
      load(c, DW'(c * 16 + 2));
    end
    run(6, 19);
    load(0, 10'h041); load(0, 10'h042); load(0, 10'h043); load(1, 10'h051);
    run(20, 26);
    load(3, 10'h071);
    run(27, 38);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
